// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction-fetch front end.
package fetch_pkg;

  localparam int FETCH_BUF_DEPTH = 2;
  localparam int INST_BYTES      = 4;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        fault;
  } fifo_entry_t;

endpackage

// File: rtl/fetch_inst_fifo.sv
// Two-entry instruction buffer between fetch and decode; flush beats push.
module fetch_inst_fifo
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  fifo_entry_t wdata_i,
  output fifo_entry_t head_o,
  output logic [1:0]  count_o
);

  fifo_entry_t mem_q [FETCH_BUF_DEPTH];
  logic        rd_q;
  logic        wr_q;
  logic [1:0]  count_q;
  logic        do_push;
  logic        do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // A push into a full buffer is fine when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != 2'(FETCH_BUF_DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      count_q <= 2'd0;
      for (int i = 0; i < FETCH_BUF_DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: one outstanding imem request, 2-entry buffer to decode, redirect flush.
// Optional macro FETCH_MISALIGN_TRAP_EN turns misaligned redirect targets into a fault entry plus HALT.
module fetch_pc_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        inst_ready,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a request/instruction transfers on a clock edge where valid && ready;
  // valid here never depends on ready, and an unaccepted request may be retracted by a redirect.

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        fault_pend_q, fault_pend_d;
  logic        started_q;
  logic [31:0] tgt_pc;
  logic        tgt_misaligned;
  logic        req_fire;
  logic        need_drain;
  logic        fifo_push, fifo_pop, fifo_flush;
  fifo_entry_t fifo_wdata, fifo_head;
  logic [1:0]  fifo_count;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt_pc         = redirect_pc;
  assign tgt_misaligned = (redirect_pc[1:0] != 2'b00);
  assign inst_fault     = inst_valid && fifo_head.fault;
`else
  logic unused_bits;
  assign tgt_pc         = {redirect_pc[31:2], 2'b00};
  assign tgt_misaligned = 1'b0;
  assign inst_fault     = 1'b0;
  assign unused_bits    = ^{redirect_pc[1:0], fifo_head.fault};
`endif

  // started_q keeps the request low until the first edge after reset release.
  assign imem_req_valid = started_q && (state_q == REQ) && (fifo_count < 2'(FETCH_BUF_DEPTH));
  assign imem_req_addr  = {pc_q[31:2], 2'b00};
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid  = (fifo_count != 2'd0);
  assign inst_data   = inst_valid ? fifo_head.data : 32'd0;
  assign inst_pc     = inst_valid ? fifo_head.pc : 32'd0;
  assign fifo_pop    = inst_valid && inst_ready && !redirect_valid;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    fault_pend_d = fault_pend_q;
    need_drain   = 1'b0;
    fifo_push    = 1'b0;
    fifo_flush   = 1'b0;
    fifo_wdata   = '{data: imem_rsp_data, pc: req_pc_q, fault: 1'b0};
    if (redirect_valid) begin
      fifo_flush   = 1'b1;
      pc_d         = tgt_pc;
      fault_pend_d = tgt_misaligned;
      // A request accepted in the redirect cycle is in flight and must be drained too.
      case (state_q)
        REQ:     need_drain = req_fire;
        WAIT:    need_drain = !imem_rsp_valid;
        DRAIN:   need_drain = !imem_rsp_valid;
        default: need_drain = 1'b0;
      endcase
      state_d = need_drain ? DRAIN : (tgt_misaligned ? HALT : REQ);
    end else begin
      case (state_q)
        REQ: if (req_fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'(INST_BYTES);
          state_d  = WAIT;
        end
        WAIT: if (imem_rsp_valid) begin
          fifo_push = 1'b1;
          state_d   = REQ;
        end
        DRAIN: if (imem_rsp_valid) state_d = fault_pend_q ? HALT : REQ;
        HALT: if (fault_pend_q) begin
          fifo_push    = 1'b1;
          fifo_wdata   = '{data: 32'd0, pc: pc_q, fault: 1'b1};
          fault_pend_d = 1'b0;
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      fault_pend_q <= 1'b0;
      started_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      fault_pend_q <= fault_pend_d;
      started_q    <= 1'b1;
    end
  end

  fetch_inst_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .wdata_i (fifo_wdata),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

endmodule
